spi_target: RTL and testbench

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_target_pkg.sv | 14 +
 rtl/spi_sync.sv | 31 +++
 rtl/spi_target.sv | 120 ++++++++++++
 tb/tb_spi_target.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared types and defaults for the SPI target.
// Holds the FSM state encoding and default word/synchronizer sizes.
package spi_target_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI input.
// Reset value is set per instance so idle levels hold through reset.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock_in,
    input  logic rs_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    generate
        if (STAGES > 1) begin : g_multi
            always_ff @(posedge clock_in or negedge rs_n) begin
                if (!rs_n) sr <= {STAGES{RST_VAL}};
                else       sr <= {sr[STAGES-2:0], d};
            end
        end else begin : g_single
            always_ff @(posedge clock_in or negedge rs_n) begin
                if (!rs_n) sr <= RST_VAL;
                else       sr <= d;
            end
        end
    endgenerate

    assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled sclk/cs/mosi, MSB-first shift in and out,
// single-word transmit holding register, continuous words per cs frame.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clock_in,
    input  logic              rs_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              led
);

    localparam int CW = $clog2(DATA_W + 1);

    logic s_sclk, s_cs, s_mosi;
    logic sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic              reload;
    logic              load_ok;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clock_in(clock_in), .rs_n(rs_n), .d(sclk), .q(s_sclk)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clock_in(clock_in), .rs_n(rs_n), .d(cs), .q(s_cs)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clock_in(clock_in), .rs_n(rs_n), .d(mosi), .q(s_mosi)
    );

    assign sclk_rise = s_sclk & ~sclk_d;
    assign sclk_fall = ~s_sclk & sclk_d;
    assign cs_rise   = s_cs & ~cs_d;
    assign cs_fall   = ~s_cs & cs_d;

    // Word boundary reload happens on the falling edge after the last bit,
    // so the next MSB is on miso before the initiator samples it.
    assign reload = ~cs_rise & ((state == ST_LOAD) |
                    ((state == ST_SHIFT) & sclk_fall & (cnt == '0)));
    assign load_ok = tx_load & ~hold_full;

    assign tx_ready = ~hold_full;
    assign miso     = ~s_cs & tx_sh[DATA_W-1];
    assign led      = rx_data[0];

    always_ff @(posedge clock_in or negedge rs_n) begin
        if (!rs_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rx_sh     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            tx_sh     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_d    <= s_sclk;
            cs_d      <= s_cs;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (load_ok) hold <= tx_data;
            hold_full <= load_ok | (hold_full & ~reload);

            if (reload)
                tx_sh <= hold_full ? hold : '0;
            else if ((state == ST_SHIFT) && sclk_fall)
                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};

            if (cs_rise) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                frame_err <= (state == ST_SHIFT) && (cnt != '0);
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        cnt <= '0;
                        if (cs_fall) state <= ST_LOAD;
                    end
                    ST_LOAD: state <= ST_SHIFT;
                    ST_SHIFT: begin
                        if (sclk_rise) begin
                            rx_sh <= {rx_sh[DATA_W-2:0], s_mosi};
                            if (cnt == CW'(DATA_W - 1)) begin
                                cnt      <= '0;
                                rx_data  <= {rx_sh[DATA_W-2:0], s_mosi};
                                rx_valid <= 1'b1;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: receive, transmit, framing and reset.
// Expected values are hand-computed from the bit patterns driven.
module tb_spi_target;

    logic       clk;
    logic       rs_n;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       led;

    int checks = 0;
    int errors = 0;

    logic [7:0] rxq[$];
    int         fcnt = 0;

    spi_target #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clock_in (clk),
        .rs_n     (rs_n),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (frame_err) fcnt++;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        wait_n(8);
    endtask

    task automatic cs_high();
        wait_n(6);
        cs = 1'b1;
        mosi = 1'b0;
        wait_n(8);
    endtask

    // Drives n bits MSB first; miso is sampled just before each rising edge.
    task automatic send_bits(input logic [7:0] d, input int n,
                             output logic [7:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            mosi = d[7-i];
            wait_n(6);
            got[7-i] = miso;
            sclk = 1'b1;
            wait_n(6);
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        rs_n = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_load = 1'b0;
        wait_n(3);
        checks++;
        if (miso !== 1'b0) begin
            errors++; $display("FAIL reset_miso got %b exp 0", miso);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready);
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data);
        end
        checks++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0 || led !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses got v=%b f=%b l=%b exp 0 0 0",
                     rx_valid, frame_err, led);
        end
        rs_n = 1'b1;
        wait_n(3);
    endtask

    task automatic test_rx_ac();
        logic [7:0] got;
        int n0;
        n0 = rxq.size();
        cs_low();
        send_bits(8'hAC, 7, got);
        mosi = 1'b0;
        wait_n(6);
        sclk = 1'b1;
        wait_n(4);
        checks++;
        if (rxq.size() != n0 + 1) begin
            errors++;
            $display("FAIL rx_latency got %0d pulses exp 1", rxq.size() - n0);
        end
        wait_n(2);
        sclk = 1'b0;
        cs_high();
        checks++;
        if (rx_data !== 8'hAC) begin
            errors++; $display("FAIL rx_ac_data got %h exp ac", rx_data);
        end
        checks++;
        if (rxq.size() != n0 + 1) begin
            errors++;
            $display("FAIL rx_ac_pulses got %0d exp 1", rxq.size() - n0);
        end
        checks++;
        if (led !== 1'b0) begin
            errors++; $display("FAIL rx_ac_led got %b exp 0", led);
        end
    endtask

    task automatic test_rx_25();
        logic [7:0] got;
        cs_low();
        send_bits(8'h25, 8, got);
        cs_high();
        checks++;
        if (rx_data !== 8'h25) begin
            errors++; $display("FAIL rx_25_data got %h exp 25", rx_data);
        end
        checks++;
        if (led !== 1'b1) begin
            errors++; $display("FAIL rx_25_led got %b exp 1", led);
        end
    endtask

    task automatic test_tx();
        logic [7:0] got;
        @(negedge clk);
        tx_data = 8'h5A;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        tx_data = 8'hFF;
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++; $display("FAIL tx_ready_after_load got %b exp 0", tx_ready);
        end
        // A second load while full must be ignored.
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        cs_low();
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL tx_ready_at_load got %b exp 1", tx_ready);
        end
        send_bits(8'h3C, 8, got);
        checks++;
        if (got !== 8'h5A) begin
            errors++; $display("FAIL tx_miso_word got %h exp 5a", got);
        end
        send_bits(8'h99, 8, got);
        checks++;
        if (got !== 8'h00) begin
            errors++; $display("FAIL tx_miso_empty got %h exp 00", got);
        end
        cs_high();
        checks++;
        if (rx_data !== 8'h99) begin
            errors++; $display("FAIL tx_rx_data got %h exp 99", rx_data);
        end
        checks++;
        if (miso !== 1'b0) begin
            errors++; $display("FAIL miso_cs_high got %b exp 0", miso);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] got;
        int n0, f0;
        n0 = rxq.size();
        f0 = fcnt;
        cs_low();
        send_bits(8'hF0, 4, got);
        cs_high();
        checks++;
        if (fcnt != f0 + 1) begin
            errors++; $display("FAIL frame_err_pulses got %0d exp 1", fcnt - f0);
        end
        checks++;
        if (rxq.size() != n0) begin
            errors++;
            $display("FAIL frame_err_rx_valid got %0d exp 0", rxq.size() - n0);
        end
        checks++;
        if (rx_data !== 8'h99) begin
            errors++; $display("FAIL frame_err_rx_data got %h exp 99", rx_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        int n0, f0;
        n0 = rxq.size();
        f0 = fcnt;
        cs_low();
        send_bits(8'h81, 8, got);
        send_bits(8'h7E, 8, got);
        cs_high();
        checks++;
        if (rxq.size() != n0 + 2) begin
            errors++; $display("FAIL b2b_pulses got %0d exp 2", rxq.size() - n0);
        end else begin
            checks++;
            if (rxq[n0] !== 8'h81) begin
                errors++; $display("FAIL b2b_word0 got %h exp 81", rxq[n0]);
            end
            checks++;
            if (rxq[n0+1] !== 8'h7E) begin
                errors++; $display("FAIL b2b_word1 got %h exp 7e", rxq[n0+1]);
            end
        end
        checks++;
        if (fcnt != f0) begin
            errors++; $display("FAIL b2b_frame_err got %0d exp 0", fcnt - f0);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] got;
        int n0, f0;
        @(negedge clk);
        tx_data = 8'hC3;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        cs_low();
        send_bits(8'hFF, 5, got);
        n0 = rxq.size();
        f0 = fcnt;
        rs_n = 1'b0;
        #1;
        checks++;
        if (miso !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_pulses got m=%b v=%b f=%b exp 0 0 0",
                     miso, rx_valid, frame_err);
        end
        checks++;
        if (rx_data !== 8'h00 || led !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_rx got %h led %b exp 00 0", rx_data, led);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_tx_ready got %b exp 1", tx_ready);
        end
        wait_n(3);
        rs_n = 1'b1;
        cs_high();
        checks++;
        if (rxq.size() != n0 || fcnt != f0) begin
            errors++;
            $display("FAIL mid_reset_spurious got v=%0d f=%0d exp 0 0",
                     rxq.size() - n0, fcnt - f0);
        end
        cs_low();
        send_bits(8'hAC, 8, got);
        cs_high();
        checks++;
        if (rx_data !== 8'hAC || rxq.size() != n0 + 1) begin
            errors++;
            $display("FAIL mid_reset_next got %h n=%0d exp ac n=1",
                     rx_data, rxq.size() - n0);
        end
        checks++;
        if (got !== 8'h00) begin
            errors++; $display("FAIL mid_reset_miso got %h exp 00", got);
        end
    endtask

    initial begin
        test_reset();
        test_rx_ac();
        test_rx_25();
        test_tx();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
